// File: rtl/bcd_pkg.sv
// Shared types and constants for the four-digit BCD scan counter.
package bcd_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [3:0] bcd_digit_t;
  typedef bcd_digit_t [NUM_DIGITS-1:0] bcd_word_t;
  typedef logic [1:0] scan_idx_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  // True when every nibble of the word is a legal decimal digit.
  function automatic logic is_valid_word(input bcd_word_t w);
    logic ok = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w[i] > BCD_MAX) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_scan_counter_if.sv
// Control and display signals of the BCD scan counter; master drives, slave is the counter.
interface bcd_scan_counter_if;

  logic        en;
  logic        up;
  logic        load;
  logic [15:0] load_val;
  logic [15:0] count;
  logic [3:0]  bcd;
  logic [3:0]  dig_sel;
  logic        tc;
  logic        load_err;

  modport master (
    output en, up, load, load_val,
    input  count, bcd, dig_sel, tc, load_err
  );

  modport slave (
    input  en, up, load, load_val,
    output count, bcd, dig_sel, tc, load_err
  );

endinterface

// File: rtl/bcd_digit.sv
// One decimal digit with load, up/down step and ripple carry/borrow.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  bcd_digit_t load_val_i,
  input  logic       up_i,
  input  logic       carry_i,
  output bcd_digit_t digit_o,
  output logic       carry_o
);

  bcd_digit_t digit_q, digit_d;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    digit_d = digit_q;
    if (load_i) begin
      digit_d = load_val_i;
    end else if (carry_i) begin
      if (up_i) digit_d = (digit_q == BCD_MAX) ? 4'd0 : digit_q + 4'd1;
      else      digit_d = (digit_q == 4'd0) ? BCD_MAX : digit_q - 4'd1;
    end
  end

  // A step request passes on only when this digit rolls over in the chosen direction.
  assign carry_o = carry_i && (up_i ? (digit_q == BCD_MAX) : (digit_q == 4'd0));
  assign digit_o = digit_q;

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) digit_q <= 4'd0;
    else        digit_q <= digit_d;
  end

endmodule

// File: rtl/bcd_scan_counter.sv
// Four-digit up/down BCD counter with validated load and a multiplexed digit scan output.
module bcd_scan_counter #(
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  bcd_scan_counter_if.slave   bus
);

  if (NUM_DIGITS != bcd_pkg::NUM_DIGITS) begin : g_bad_num_digits
    $error("bcd_scan_counter supports exactly four digits");
  end
  if (SCAN_DIV < 1 || SCAN_DIV > 65535) begin : g_bad_scan_div
    $error("bcd_scan_counter SCAN_DIV must be in 1..65535");
  end

  localparam logic [15:0] PRESC_LAST = 16'(SCAN_DIV - 1);

  bcd_pkg::bcd_word_t count;
  logic               load_ok;
  logic               load_bad;
  logic               step_en;
  logic [bcd_pkg::NUM_DIGITS:0] carry;

  logic               tc_q, load_err_q;
  logic [15:0]        presc_q, presc_d;
  bcd_pkg::scan_idx_t scan_idx_q, scan_idx_d;

  // A rejected load still owns the cycle, so it blocks counting as well.
  assign load_ok  = bus.load &&  bcd_pkg::is_valid_word(bus.load_val);
  assign load_bad = bus.load && !bcd_pkg::is_valid_word(bus.load_val);
  assign step_en  = bus.en && !bus.load;
  assign carry[0] = step_en;

  for (genvar i = 0; i < bcd_pkg::NUM_DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (load_ok),
      .load_val_i (bus.load_val[4*i +: 4]),
      .up_i       (bus.up),
      .carry_i    (carry[i]),
      .digit_o    (count[i]),
      .carry_o    (carry[i+1])
    );
  end

  always_comb begin
    presc_d    = presc_q + 16'd1;
    scan_idx_d = scan_idx_q;
    if (presc_q == PRESC_LAST) begin
      presc_d    = 16'd0;
      scan_idx_d = scan_idx_q + 2'd1;
    end
  end

  // Carry out of the top digit is the wrap event; loads gate the chain so they never flag tc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tc_q       <= 1'b0;
      load_err_q <= 1'b0;
      presc_q    <= 16'd0;
      scan_idx_q <= 2'd0;
    end else begin
      tc_q       <= carry[bcd_pkg::NUM_DIGITS];
      load_err_q <= load_bad;
      presc_q    <= presc_d;
      scan_idx_q <= scan_idx_d;
    end
  end

  assign bus.count    = count;
  assign bus.bcd      = count[scan_idx_q];
  assign bus.dig_sel  = 4'b0001 << scan_idx_q;
  assign bus.tc       = tc_q;
  assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Self-checking bench: directed scenarios plus random traffic against an integer reference model.
module tb_bcd_scan_counter;

  localparam int SCAN_DIV = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_scan_counter_if bus ();

  bcd_scan_counter #(.SCAN_DIV(SCAN_DIV), .NUM_DIGITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: count as a plain integer 0..9999, scan position from edges since reset.
  int m_val = 0;
  int m_cyc = 0;
  bit m_tc  = 1'b0;
  bit m_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int to_int(input logic [15:0] b);
    return int'(b[3:0]) + 10 * int'(b[7:4]) + 100 * int'(b[11:8]) + 1000 * int'(b[15:12]);
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int d = 1;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'((v / d) % 10);
      d = d * 10;
    end
    return r;
  endfunction

  function automatic bit all_decimal(input logic [15:0] b);
    for (int i = 0; i < 4; i++) if (b[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int exp_idx();
    return (m_cyc / SCAN_DIV) % 4;
  endfunction

  function automatic logic [3:0] exp_bcd();
    int d = 1;
    for (int i = 0; i < exp_idx(); i++) d = d * 10;
    return 4'((m_val / d) % 10);
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".count"},    bus.count,    to_bcd(m_val));
    check({tag, ".tc"},       bus.tc,       m_tc);
    check({tag, ".load_err"}, bus.load_err, m_err);
    check({tag, ".dig_sel"},  bus.dig_sel,  4'b0001 << exp_idx());
    check({tag, ".bcd"},      bus.bcd,      exp_bcd());
  endtask

  task automatic drive(input bit ld, input logic [15:0] lv, input bit en, input bit up);
    bus.load     = ld;
    bus.load_val = lv;
    bus.en       = en;
    bus.up       = up;
  endtask

  // One clock: advance the model on the inputs present at the edge, then compare just after it.
  task automatic step(input string tag);
    @(posedge clk);
    m_tc  = 1'b0;
    m_err = 1'b0;
    if (bus.load) begin
      if (all_decimal(bus.load_val)) m_val = to_int(bus.load_val);
      else                           m_err = 1'b1;
    end else if (bus.en) begin
      if (bus.up) begin
        m_tc  = (m_val == 9999);
        m_val = (m_val + 1) % 10000;
      end else begin
        m_tc  = (m_val == 0);
        m_val = (m_val + 9999) % 10000;
      end
    end
    m_cyc++;
    #1;
    compare_all(tag);
  endtask

  task automatic model_reset();
    m_val = 0;
    m_cyc = 0;
    m_tc  = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    model_reset();
    #1;
    compare_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    #12;
    compare_all("reset0");
    do_reset();

    // Increment across 9999 -> 0000.
    drive(1'b1, 16'h9998, 1'b0, 1'b0); step("inc_ld");
    drive(1'b0, 16'h0000, 1'b1, 1'b1); step("inc1");
    check("inc1.const", bus.count, 16'h9999);
    step("inc2");
    check("inc2.const", bus.count, 16'h0000);
    check("inc2.tc", bus.tc, 1'b1);
    step("inc3");
    check("inc3.const", bus.count, 16'h0001);

    // Decrement across 0000 -> 9999, and borrows through middle digits.
    drive(1'b1, 16'h0001, 1'b0, 1'b0); step("dec_ld");
    drive(1'b0, 16'h0000, 1'b1, 1'b0); step("dec1");
    step("dec2");
    check("dec2.const", bus.count, 16'h9999);
    drive(1'b1, 16'h0109, 1'b0, 1'b0); step("dec_ld2");
    drive(1'b0, 16'h0000, 1'b1, 1'b0); step("dec3");
    check("dec3.const", bus.count, 16'h0108);
    drive(1'b1, 16'h0100, 1'b0, 1'b0); step("dec_ld3");
    drive(1'b0, 16'h0000, 1'b1, 1'b0); step("dec4");
    check("dec4.const", bus.count, 16'h0099);

    // Rejected load with en high: value held, one-cycle error.
    drive(1'b1, 16'h1234, 1'b0, 1'b0); step("err_ld");
    drive(1'b1, 16'h12A4, 1'b1, 1'b1); step("err1");
    check("err1.const", bus.load_err, 1'b1);
    drive(1'b0, 16'h0000, 1'b0, 1'b1); step("err2");

    // Load beats en; a valid load at 9999 -> 0000 never flags tc.
    drive(1'b1, 16'h0500, 1'b1, 1'b1); step("prio");
    check("prio.const", bus.count, 16'h0500);
    drive(1'b1, 16'h9999, 1'b0, 1'b0); step("ldtc1");
    drive(1'b1, 16'h0000, 1'b1, 1'b1); step("ldtc2");

    // Scan pattern for 4321 over more than one 12-cycle period.
    do_reset();
    drive(1'b1, 16'h4321, 1'b0, 1'b0); step("scan_ld");
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) step("scan");

    // Asynchronous reset in mid-scan with count 0567 shown at index 2.
    do_reset();
    drive(1'b1, 16'h0567, 1'b0, 1'b0); step("ar_ld");
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 12 && exp_idx() != 2; i++) step("ar_wait");
    check("ar.idx_reached", bus.dig_sel, 4'b0100);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    compare_all("ar.async");
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 16'h0000, 1'b1, 1'b1);
    step("ar_first");
    check("ar_first.const", bus.count, 16'h0001);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] lv;
      lv = ($urandom_range(0, 1) == 0) ? to_bcd(int'($urandom_range(0, 9999))) : 16'($urandom);
      drive($urandom_range(0, 7) == 0, lv, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_scan_counter.md
BCD_SCAN_COUNTER -- requirements
Module: bcd_scan_counter

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clocks per displayed digit; legal range 1..65535.
REQ-002 Parameter NUM_DIGITS, default 4: fixed at 4; other values unsupported.
REQ-003 One clock; reset is asynchronous and active-low. Ports are clk and rst_n.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 en  in  1  count enable: one BCD step per cycle while high.
REQ-007 up  in  1  direction: 1 = increment, 0 = decrement.
REQ-008 load  in  1  synchronous load request.
REQ-009 load_val  in  16  four packed BCD digits, [3:0] = least-significant digit.
REQ-010 count  out  16  current four-digit BCD value, same packing as load_val.
REQ-011 bcd  out  4  digit currently scanned; feeds the seven-segment decoder bcd input.
REQ-012 dig_sel  out  4  one-hot, active-high digit enable; bit i selects count[4i+3:4i].
REQ-013 tc  out  1  terminal-count pulse on wrap.
REQ-014 load_err  out  1  pulse when a load is rejected.

Function
REQ-015 Priority per cycle SHALL be load > en > hold.
REQ-016 A load with every load_val nibble <= 9 SHALL set count = load_val at that edge; visible the next cycle.
REQ-017 A load with any nibble > 9 SHALL leave count unchanged and SHALL hold load_err high for exactly the following cycle. en is ignored that cycle.
REQ-018 With en=1, up=1 and load=0, count SHALL increment in decimal: digit 9 -> 0 with carry into the next digit.
REQ-019 With en=1, up=0 and load=0, count SHALL decrement in decimal: digit 0 -> 9 with borrow from the next digit.
REQ-020 Increment from 9999 SHALL wrap to 0000. Decrement from 0000 SHALL wrap to 9999.
REQ-021 tc SHALL be registered and high for exactly the one cycle after each wrap edge. Consecutive wraps SHALL give consecutive pulses.
REQ-022 A valid load SHALL never assert tc, whatever the value loaded.
REQ-023 No count nibble SHALL ever hold a value above 9.
REQ-024 A prescaler SHALL count 0..SCAN_DIV-1 continuously, independent of en and load.
REQ-025 At prescaler terminal, the scan index SHALL advance 0->1->2->3->0 and the prescaler SHALL return to 0.
REQ-026 With SCAN_DIV=1, the scan index SHALL advance every cycle.
REQ-027 dig_sel SHALL equal the one-hot of the scan index.
REQ-028 bcd SHALL equal the count nibble selected by the scan index (combinational from registered state), so a count change is reflected in bcd in the same cycle as count.
REQ-029 dig_sel SHALL never be zero or multi-hot outside reset.

Reset
REQ-030 While rst_n=0, asynchronously: count=0000, prescaler=0, scan index=0, dig_sel=0001, bcd=0, tc=0, load_err=0.
REQ-031 Reset asserted mid-count or mid-scan SHALL abort immediately. There SHALL be no pending tc or load_err after release.
REQ-032 The first count step after release SHALL occur on the first rising edge with rst_n=1 and en=1.

Structure
REQ-033 Shared package bcd_pkg SHALL hold BCD_MAX (4'd9), NUM_DIGITS (4), a bcd_digit_t 4-bit typedef, and a packed 4-digit array typedef.
REQ-034 Sub-module bcd_digit SHALL implement one decimal digit: load, step, direction, carry/borrow in, and carry/borrow out. It is instantiated four times in a ripple chain.
REQ-035 The prescaler, scan index, and tc/load_err registers SHALL reside in bcd_scan_counter.

Verification
REQ-036 Load 0x9998, en=1, up=1 for 3 cycles -> count 9999, 0000, 0001; tc high only the cycle count first reads 0000.
REQ-037 Load 0x0001, en=1, up=0 for 2 cycles -> count 0000, 9999; one tc pulse; 0x0109 decremented once -> 0x0108, 0x0100 decremented once -> 0x0099.
REQ-038 Count 0x1234; load with load_val 0x12A4 and en=1 -> count stays 0x1234, load_err high one cycle, tc low.
REQ-039 SCAN_DIV=3, count 0x4321 -> dig_sel 0001/bcd 1 for 3 cycles, then 0010/2, 0100/3, 1000/4, then back to 0001; period 12 cycles.
REQ-040 Assert rst_n=0 asynchronously while count=0x0567 with the scan index at 2 -> all outputs take reset values before the next clk edge; after release, en=1 gives count 0x0001.
REQ-041 load=1 and en=1 together with load_val 0x0500 -> count 0x0500, not 0x0501; no tc.
